inst_queue: RTL and testbench

- Small instruction buffer directly downstream of the fetch stage; upstream of decode.
- Accepts {inst, pc} pairs from fetch over a valid/ready handshake and holds up to DEPTH entries.
- Presents the oldest entry to decode with pre-decoded branch flag and B-type imm32, which feed back to fetch's branch/imm32 inputs.
- Flush discards all buffered entries on a taken branch or redirect.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/inst_queue.sv | 104 ++++++++++
 tb/tb_inst_queue.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU constants and the B-type immediate helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int          XLEN       = 32;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] NOP_INST   = 32'h00000013;

    // Sign-extended B-type branch offset (always even).
    function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] inst);
        return {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_queue.sv
// ============================================================================
// Module      : inst_queue
// Description : Fetch-to-decode instruction buffer with branch pre-decode.
//               Optional INST_QUEUE_BYPASS_EN: empty-queue pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = cpu_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_inst,
    input  logic [XLEN-1:0]          in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_inst,
    output logic [XLEN-1:0]          out_pc,
    output logic                     out_branch,
    output logic [XLEN-1:0]          out_imm32,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_inst_mem [DEPTH];
    logic [XLEN-1:0] r_pc_mem   [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign in_ready = !w_full;
    assign count    = r_count;

`ifdef INST_QUEUE_BYPASS_EN
    assign w_bypass = w_empty & in_valid & !flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed entry consumed the same cycle is never written.
    assign w_push = in_valid & in_ready & !flush & !(w_bypass & out_ready);
    assign w_pop  = out_valid & out_ready & !flush & !w_bypass;

    always_comb begin
        out_valid = !w_empty;
        out_inst  = w_empty ? NOP_INST : r_inst_mem[r_rd_ptr];
        out_pc    = w_empty ? '0 : r_pc_mem[r_rd_ptr];
        if (w_bypass) begin
            out_valid = 1'b1;
            out_inst  = in_inst;
            out_pc    = in_pc;
        end
        out_branch = out_valid & (out_inst[6:0] == OPC_BRANCH);
        out_imm32  = imm_b(out_inst);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_inst_mem[r_wr_ptr] <= in_inst;
            r_pc_mem[r_wr_ptr]   <= in_pc;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
// ============================================================================
// Module      : tb_inst_queue
// Description : Randomized self-checking bench for inst_queue against a
//               queue-based reference model plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_queue;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc;
    logic            out_branch;
    logic [XLEN-1:0] out_imm32;
    logic [CW-1:0]   count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t mq[$];

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_branch (out_branch),
        .out_imm32  (out_imm32),
        .count      (count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Branch offset as a plain signed sum of its weighted bit fields.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int v;
        v = (int'(i[7]) * 2048) + (int'(i[30:25]) * 32) + (int'(i[11:8]) * 2);
        if (i[31]) v = v - 4096;
        return 32'(v);
    endfunction

    function automatic bit model_bypass();
`ifdef INST_QUEUE_BYPASS_EN
        return (mq.size() == 0) && in_valid && !flush;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: one step per clock edge.
    always @(posedge clk) begin
        if (rst || flush) begin
            mq.delete();
        end else if (!(model_bypass() && out_ready)) begin
            bit do_pop;
            bit do_push;
            do_pop  = (mq.size() > 0) && out_ready;
            do_push = in_valid && (mq.size() < DEPTH);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{inst: in_inst, pc: in_pc});
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_valid;
            logic [31:0] e_inst;
            logic [31:0] e_pc;
            if (model_bypass()) begin
                e_valid = 1'b1; e_inst = in_inst; e_pc = in_pc;
            end else if (mq.size() > 0) begin
                e_valid = 1'b1; e_inst = mq[0].inst; e_pc = mq[0].pc;
            end else begin
                e_valid = 1'b0; e_inst = 32'h00000013; e_pc = 32'h0;
            end
            check("m_valid",  32'(out_valid), 32'(e_valid));
            check("m_inst",   out_inst, e_inst);
            check("m_pc",     out_pc, e_pc);
            check("m_branch", 32'(out_branch), 32'(e_valid && (e_inst[6:0] == 7'h63)));
            check("m_imm32",  out_imm32, ref_imm(e_inst));
            check("m_count",  32'(count), 32'(mq.size()));
            check("m_ready",  32'(in_ready), 32'(mq.size() != DEPTH));
        end
    end

    task automatic edge_drive();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pc_ctr;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'h0; in_pc = 32'h0;
        edge_drive();
        edge_drive();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_inst",  out_inst, 32'h00000013);
        check("rst_pc",    out_pc, 32'h0);
        check("rst_ready", 32'(in_ready), 32'd1);

        // Single push, one-cycle latency
        in_valid = 1'b1; in_inst = 32'h00A00093; in_pc = 32'h0;
        edge_drive();
        in_valid = 1'b0;
        @(negedge clk);
        check("p1_valid",  32'(out_valid), 32'd1);
        check("p1_inst",   out_inst, 32'h00A00093);
        check("p1_pc",     out_pc, 32'h0);
        check("p1_branch", 32'(out_branch), 32'd0);
        check("p1_count",  32'(count), 32'd1);
        out_ready = 1'b1;
        edge_drive();
        out_ready = 1'b0;

        // Fill to full; third entry held until a pop frees space
        in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'd0;
        edge_drive();
        in_pc = 32'd4;
        edge_drive();
        in_pc = 32'd8;
        @(negedge clk);
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_count", 32'(count), 32'd2);
        edge_drive();
        @(negedge clk);
        check("held_count", 32'(count), 32'd2);
        check("held_pc",    out_pc, 32'd0);
        out_ready = 1'b1;
        edge_drive();
        out_ready = 1'b0;
        @(negedge clk);
        check("afterpop_count", 32'(count), 32'd1);
        check("afterpop_ready", 32'(in_ready), 32'd1);
        check("afterpop_pc",    out_pc, 32'd4);
        edge_drive();
        in_valid = 1'b0;
        @(negedge clk);
        check("pc8_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        edge_drive();
        edge_drive();
        out_ready = 1'b0;

        // Steady push+pop at count=1 with pointer wrap
        in_valid = 1'b1; in_pc = 32'd0;
        edge_drive();
        out_ready = 1'b1; in_pc = 32'd4;
        @(negedge clk);
        check("stream_pc0", out_pc, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            edge_drive();
            in_pc = 32'(4 * (k + 1));
            @(negedge clk);
            check("stream_count", 32'(count), 32'd1);
            check("stream_pc",    out_pc, 32'(4 * k));
        end
        edge_drive();
        in_valid = 1'b0;
        edge_drive();
        out_ready = 1'b0;

        // Branch pre-decode, then flush with a same-cycle push attempt
        in_valid = 1'b1; in_inst = 32'hFE000EE3; in_pc = 32'd100;
        edge_drive();
        in_inst = 32'h00A00093; in_pc = 32'd104;
        @(negedge clk);
        check("beq_branch", 32'(out_branch), 32'd1);
        check("beq_imm",    out_imm32, 32'hFFFFFFFC);
        edge_drive();
        flush = 1'b1; in_inst = 32'hDEADBEEF; in_pc = 32'd200;
        @(negedge clk);
        check("flushcyc_valid", 32'(out_valid), 32'd1);
        check("flushcyc_inst",  out_inst, 32'hFE000EE3);
        check("flushcyc_count", 32'(count), 32'd2);
        edge_drive();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_inst",  out_inst, 32'h00000013);

`ifdef INST_QUEUE_BYPASS_EN
        // Zero-latency pass-through on an empty queue
        in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'h00100113; in_pc = 32'd300;
        @(negedge clk);
        check("byp_valid", 32'(out_valid), 32'd1);
        check("byp_inst",  out_inst, 32'h00100113);
        edge_drive();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("byp_count", 32'(count), 32'd0);
`endif

        // Randomized traffic checked by the per-cycle compare
        pc_ctr = 32'h1000;
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 63) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_inst   = $urandom;
            if ($urandom_range(0, 2) == 0) in_inst[6:0] = 7'h63;
            in_pc     = pc_ctr;
            pc_ctr    = pc_ctr + 32'd4;
            edge_drive();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
